// File: rtl/arbiter_4req.sv
// Four-requester arbiter with registered one-hot grant and a hold limit that forces
// release when others wait. Define ARBITER_4REQ_ROUND_ROBIN_EN for round-robin order; default is fixed priority.
module arbiter_4req #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] others;
    logic [3:0] cand;
    logic       new_grant;
    logic [1:0] win;
    logic       found;

`ifdef ARBITER_4REQ_ROUND_ROBIN_EN
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] idx;

    // Search starts just past the last owner; the first hit in rotation order wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'd1 + 2'(k);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Ascending scan lets the highest-index requester overwrite lower ones.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (cand[k]) begin
                win   = 2'(k);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        cand      = '0;
        new_grant = 1'b0;
        others    = req & ~(4'b0001 << owner);
        case (state)
            IDLE: begin
                if (|req) begin
                    cand      = req;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    if (|others) begin
                        cand      = others;
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                        cnt_nxt   = '0;
                    end
                end else if (cnt == HOLD_LIMIT && |others) begin
                    cand      = others;
                    new_grant = 1'b1;
                end else if (cnt != HOLD_LIMIT) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (new_grant && found) begin
            state_nxt = GRANT;
            owner_nxt = win;
            cnt_nxt   = 8'd1;
        end
    end

`ifdef ARBITER_4REQ_ROUND_ROBIN_EN
    always_comb begin
        ptr_nxt = ptr;
        if (new_grant && found) ptr_nxt = win;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= 2'd3;
        else     ptr <= ptr_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
            gnt    <= (state_nxt == GRANT) ? (4'b0001 << owner_nxt) : 4'b0000;
            gnt_id <= (state_nxt == GRANT) ? owner_nxt : 2'd0;
            valid  <= (state_nxt == GRANT);
        end
    end

endmodule
